// File: rtl/mips_multicycle_control_if.sv
// Control/status bundle between the multicycle control FSM and the MIPS datapath.
// The controller is the master: it consumes IR fields and the zero flag, drives strobes/selects.
interface mips_multicycle_control_if #(
  parameter int unsigned STATE_W = 4
);
  logic [5:0]         op;
  logic [5:0]         funct;
  logic               zero;
  logic               pc_en;
  logic               ir_en;
  logic               mem_write;
  logic               reg_write;
  logic               iord;
  logic               mem_to_reg;
  logic               reg_dst;
  logic               alu_src_a;
  logic [1:0]         alu_src_b;
  logic [1:0]         pc_src;
  logic [2:0]         alu_control;
  logic [STATE_W-1:0] state;

  modport master (
    input  op, funct, zero,
    output pc_en, ir_en, mem_write, reg_write, iord, mem_to_reg, reg_dst,
           alu_src_a, alu_src_b, pc_src, alu_control, state
  );

  modport slave (
    output op, funct, zero,
    input  pc_en, ir_en, mem_write, reg_write, iord, mem_to_reg, reg_dst,
           alu_src_a, alu_src_b, pc_src, alu_control, state
  );
endinterface

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath; pc_en additionally follows zero in BRANCH.
// Write strobes are masked combinationally while reset is low so no write slips through.
module mips_multicycle_control #(
  parameter int unsigned STATE_W = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  mips_multicycle_control_if.master bus
);

  typedef enum logic [STATE_W-1:0] {
    FETCH  = STATE_W'(0),
    DECODE = STATE_W'(1),
    MEMADR = STATE_W'(2),
    MEMRD  = STATE_W'(3),
    MEMWB  = STATE_W'(4),
    MEMWR  = STATE_W'(5),
    EXEC   = STATE_W'(6),
    ALUWB  = STATE_W'(7),
    BRANCH = STATE_W'(8),
    ADDIEX = STATE_W'(9),
    ADDIWB = STATE_W'(10),
    JUMP   = STATE_W'(11)
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q, state_d;

  always_comb begin
    state_d = FETCH;
    case (state_q)
      FETCH:  state_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_LW, OP_SW: state_d = MEMADR;
          OP_RTYPE:     state_d = EXEC;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
          OP_J:         state_d = JUMP;
          default:      state_d = FETCH;
        endcase
      end
      MEMADR: state_d = (bus.op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  state_d = MEMWB;
      EXEC:   state_d = ALUWB;
      ADDIEX: state_d = ADDIWB;
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state_q <= FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    bus.pc_en       = 1'b0;
    bus.ir_en       = 1'b0;
    bus.mem_write   = 1'b0;
    bus.reg_write   = 1'b0;
    bus.iord        = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.alu_src_a   = 1'b0;
    bus.alu_src_b   = 2'b00;
    bus.pc_src      = 2'b00;
    bus.alu_control = ALU_ADD;
    if (!reset) begin
      // Present FETCH selects with all strobes held off.
      bus.alu_src_b = 2'b01;
    end else begin
      case (state_q)
        FETCH: begin
          bus.ir_en     = 1'b1;
          bus.pc_en     = 1'b1;
          bus.alu_src_b = 2'b01;
        end
        DECODE: bus.alu_src_b = 2'b11;
        MEMADR, ADDIEX: begin
          bus.alu_src_a = 1'b1;
          bus.alu_src_b = 2'b10;
        end
        MEMRD: bus.iord = 1'b1;
        MEMWR: begin
          bus.iord      = 1'b1;
          bus.mem_write = 1'b1;
        end
        MEMWB: begin
          bus.mem_to_reg = 1'b1;
          bus.reg_write  = 1'b1;
        end
        EXEC: begin
          bus.alu_src_a = 1'b1;
          case (bus.funct)
            6'b100010: bus.alu_control = ALU_SUB;
            6'b100100: bus.alu_control = ALU_AND;
            6'b100101: bus.alu_control = ALU_OR;
            6'b101010: bus.alu_control = ALU_SLT;
            default:   bus.alu_control = ALU_ADD;
          endcase
        end
        ALUWB: begin
          bus.reg_dst   = 1'b1;
          bus.reg_write = 1'b1;
        end
        ADDIWB: bus.reg_write = 1'b1;
        BRANCH: begin
          bus.alu_src_a   = 1'b1;
          bus.alu_control = ALU_SUB;
          bus.pc_src      = 2'b01;
          bus.pc_en       = bus.zero;
        end
        JUMP: begin
          bus.pc_src = 2'b10;
          bus.pc_en  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.state = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for the multicycle MIPS control FSM: state sequences and per-state controls.
module tb_mips_multicycle_control;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mips_multicycle_control_if #(.STATE_W(4)) bus ();

  mips_multicycle_control #(.STATE_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    total++;
    if ({bus.pc_en, bus.ir_en, bus.mem_write, bus.reg_write} !== 4'b0000) begin
      bad++; $display("FAIL rst_strobes_pre got=%b exp=0000", {bus.pc_en, bus.ir_en, bus.mem_write, bus.reg_write});
    end
    tick();
    tick();
    total++;
    if (bus.state !== 4'd0) begin bad++; $display("FAIL rst_state got=%0d exp=0", bus.state); end
    total++;
    if ({bus.pc_en, bus.ir_en, bus.mem_write, bus.reg_write} !== 4'b0000) begin
      bad++; $display("FAIL rst_strobes_held got=%b exp=0000", {bus.pc_en, bus.ir_en, bus.mem_write, bus.reg_write});
    end
    total++;
    if (bus.alu_src_b !== 2'b01 || bus.alu_control !== 3'b010) begin
      bad++; $display("FAIL rst_selects got=%b/%b exp=01/010", bus.alu_src_b, bus.alu_control);
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus.state !== 4'd0 || bus.pc_en !== 1'b1 || bus.ir_en !== 1'b1) begin
      bad++; $display("FAIL rst_release got=st%0d pc%b ir%b exp=st0 pc1 ir1", bus.state, bus.pc_en, bus.ir_en);
    end
  endtask

  task automatic test_lw();
    bus.op = 6'b100011; bus.funct = 6'b000000; bus.zero = 1'b0;
    total++;
    if (bus.state !== 4'd0 || bus.alu_src_b !== 2'b01) begin
      bad++; $display("FAIL lw_fetch got=st%0d srcb%b exp=st0 srcb01", bus.state, bus.alu_src_b);
    end
    tick();
    total++;
    if (bus.state !== 4'd1 || bus.alu_src_b !== 2'b11) begin
      bad++; $display("FAIL lw_decode got=st%0d srcb%b exp=st1 srcb11", bus.state, bus.alu_src_b);
    end
    tick();
    total++;
    if (bus.state !== 4'd2 || bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b10) begin
      bad++; $display("FAIL lw_memadr got=st%0d a%b b%b exp=st2 a1 b10", bus.state, bus.alu_src_a, bus.alu_src_b);
    end
    tick();
    bus.op = 6'b111111;
    total++;
    if (bus.state !== 4'd3 || bus.iord !== 1'b1 || bus.reg_write !== 1'b0) begin
      bad++; $display("FAIL lw_memrd got=st%0d iord%b rw%b exp=st3 iord1 rw0", bus.state, bus.iord, bus.reg_write);
    end
    tick();
    total++;
    if (bus.state !== 4'd4 || bus.reg_write !== 1'b1 || bus.mem_to_reg !== 1'b1 || bus.reg_dst !== 1'b0) begin
      bad++; $display("FAIL lw_memwb got=st%0d rw%b m2r%b rd%b exp=st4 rw1 m2r1 rd0",
                      bus.state, bus.reg_write, bus.mem_to_reg, bus.reg_dst);
    end
    tick();
    total++;
    if (bus.state !== 4'd0) begin bad++; $display("FAIL lw_end got=%0d exp=0", bus.state); end
  endtask

  task automatic test_rtype(input logic [5:0] fn, input logic [2:0] exp_alu);
    bus.op = 6'b000000; bus.funct = fn;
    tick();
    total++;
    if (bus.state !== 4'd1) begin bad++; $display("FAIL r_decode fn=%b got=%0d exp=1", fn, bus.state); end
    tick();
    total++;
    if (bus.state !== 4'd6 || bus.alu_control !== exp_alu || bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b00) begin
      bad++; $display("FAIL r_exec fn=%b got=st%0d alu%b a%b b%b exp=st6 alu%b a1 b00",
                      fn, bus.state, bus.alu_control, bus.alu_src_a, bus.alu_src_b, exp_alu);
    end
    tick();
    total++;
    if (bus.state !== 4'd7 || bus.reg_write !== 1'b1 || bus.reg_dst !== 1'b1 || bus.mem_to_reg !== 1'b0) begin
      bad++; $display("FAIL r_aluwb fn=%b got=st%0d rw%b rd%b m2r%b exp=st7 rw1 rd1 m2r0",
                      fn, bus.state, bus.reg_write, bus.reg_dst, bus.mem_to_reg);
    end
    tick();
    total++;
    if (bus.state !== 4'd0) begin bad++; $display("FAIL r_end fn=%b got=%0d exp=0", fn, bus.state); end
  endtask

  task automatic test_branch(input logic z);
    bus.op = 6'b000100; bus.zero = z;
    tick();
    tick();
    total++;
    if (bus.state !== 4'd8 || bus.pc_src !== 2'b01 || bus.pc_en !== z || bus.alu_control !== 3'b110) begin
      bad++; $display("FAIL beq_z%b got=st%0d src%b pcen%b alu%b exp=st8 src01 pcen%b alu110",
                      z, bus.state, bus.pc_src, bus.pc_en, bus.alu_control, z);
    end
    tick();
    total++;
    if (bus.state !== 4'd0) begin bad++; $display("FAIL beq_end_z%b got=%0d exp=0", z, bus.state); end
    bus.zero = 1'b0;
  endtask

  task automatic test_sw_jump_addi();
    bus.op = 6'b101011;
    tick();
    total++;
    if (bus.mem_write !== 1'b0) begin bad++; $display("FAIL sw_decode_mw got=%b exp=0", bus.mem_write); end
    tick();
    total++;
    if (bus.state !== 4'd2 || bus.mem_write !== 1'b0) begin
      bad++; $display("FAIL sw_memadr got=st%0d mw%b exp=st2 mw0", bus.state, bus.mem_write);
    end
    tick();
    total++;
    if (bus.state !== 4'd5 || bus.mem_write !== 1'b1 || bus.iord !== 1'b1) begin
      bad++; $display("FAIL sw_memwr got=st%0d mw%b iord%b exp=st5 mw1 iord1", bus.state, bus.mem_write, bus.iord);
    end
    tick();
    total++;
    if (bus.state !== 4'd0 || bus.mem_write !== 1'b0) begin
      bad++; $display("FAIL sw_end got=st%0d mw%b exp=st0 mw0", bus.state, bus.mem_write);
    end
    bus.op = 6'b000010;
    tick();
    tick();
    total++;
    if (bus.state !== 4'd11 || bus.pc_src !== 2'b10 || bus.pc_en !== 1'b1) begin
      bad++; $display("FAIL j_jump got=st%0d src%b pcen%b exp=st11 src10 pcen1", bus.state, bus.pc_src, bus.pc_en);
    end
    tick();
    total++;
    if (bus.state !== 4'd0) begin bad++; $display("FAIL j_end got=%0d exp=0", bus.state); end
    bus.op = 6'b001000;
    tick();
    tick();
    total++;
    if (bus.state !== 4'd9 || bus.alu_src_a !== 1'b1 || bus.alu_src_b !== 2'b10) begin
      bad++; $display("FAIL addi_ex got=st%0d a%b b%b exp=st9 a1 b10", bus.state, bus.alu_src_a, bus.alu_src_b);
    end
    tick();
    total++;
    if (bus.state !== 4'd10 || bus.reg_write !== 1'b1 || bus.reg_dst !== 1'b0 || bus.mem_to_reg !== 1'b0) begin
      bad++; $display("FAIL addi_wb got=st%0d rw%b rd%b m2r%b exp=st10 rw1 rd0 m2r0",
                      bus.state, bus.reg_write, bus.reg_dst, bus.mem_to_reg);
    end
    tick();
    total++;
    if (bus.state !== 4'd0) begin bad++; $display("FAIL addi_end got=%0d exp=0", bus.state); end
  endtask

  task automatic test_unknown_op();
    bus.op = 6'b111111;
    tick();
    total++;
    if (bus.state !== 4'd1 || {bus.mem_write, bus.reg_write} !== 2'b00) begin
      bad++; $display("FAIL nop_decode got=st%0d w%b exp=st1 w00", bus.state, {bus.mem_write, bus.reg_write});
    end
    tick();
    total++;
    if (bus.state !== 4'd0) begin bad++; $display("FAIL nop_end got=%0d exp=0", bus.state); end
  endtask

  task automatic test_reset_mid_sw();
    bus.op = 6'b101011;
    tick();
    tick();
    tick();
    total++;
    if (bus.state !== 4'd5 || bus.mem_write !== 1'b1) begin
      bad++; $display("FAIL midrst_pre got=st%0d mw%b exp=st5 mw1", bus.state, bus.mem_write);
    end
    reset = 1'b0;
    #1;
    total++;
    if (bus.mem_write !== 1'b0 || bus.iord !== 1'b0) begin
      bad++; $display("FAIL midrst_mask got=mw%b iord%b exp=mw0 iord0", bus.mem_write, bus.iord);
    end
    tick();
    total++;
    if (bus.state !== 4'd0 || bus.ir_en !== 1'b0) begin
      bad++; $display("FAIL midrst_state got=st%0d ir%b exp=st0 ir0", bus.state, bus.ir_en);
    end
    reset = 1'b1;
    #1;
    total++;
    if (bus.ir_en !== 1'b1 || bus.pc_en !== 1'b1) begin
      bad++; $display("FAIL midrst_release got=ir%b pc%b exp=ir1 pc1", bus.ir_en, bus.pc_en);
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    bus.op = 6'b000000;
    bus.funct = 6'b000000;
    bus.zero = 1'b0;
    test_reset();
    test_lw();
    test_rtype(6'b100010, 3'b110);
    test_rtype(6'b101010, 3'b111);
    test_rtype(6'b100100, 3'b000);
    test_rtype(6'b100101, 3'b001);
    test_rtype(6'b000000, 3'b010);
    test_branch(1'b1);
    test_branch(1'b0);
    test_sw_jump_addi();
    test_unknown_op();
    test_reset_mid_sw();
    test_lw();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
